player_move_ctrl: RTL and testbench

//  Grid-position controller for the player sprite. Debounces four raw direction

---
 rtl/player_move_ctrl_if.sv | 21 ++
 rtl/player_move_ctrl.sv | 110 +++++++++++
 tb/tb_player_move_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/player_move_ctrl_if.sv
// Button inputs and position outputs of the player movement controller.
// The controller is the slave; whatever drives the buttons is the master.
interface player_move_ctrl_if;
    logic       i_player_up;
    logic       i_player_down;
    logic       i_player_left;
    logic       i_player_right;
    logic [4:0] o_player_x;
    logic [3:0] o_player_y;
    logic       o_reset;

    modport master (
        output i_player_up, i_player_down, i_player_left, i_player_right,
        input  o_player_x, o_player_y, o_reset
    );

    modport slave (
        input  i_player_up, i_player_down, i_player_left, i_player_right,
        output o_player_x, o_player_y, o_reset
    );
endinterface

// File: rtl/player_move_ctrl.sv
// Player tile-position controller: debounces four direction buttons and steps the
// player one tile per button release, clamped to the play field (x 1..20, y 0..14).
// Reaching the top row respawns the player at its origin on the following cycle.
module player_move_ctrl #(
    parameter logic [4:0]  PLAYER_ORIGIN_X = 5'd11,
    parameter logic [3:0]  PLAYER_ORIGIN_Y = 4'd14,
    parameter int unsigned DEBOUNCE_LIMIT  = 250000
) (
    input logic               i_Clk,
    input logic               i_reset,
    player_move_ctrl_if.slave bus
);

    localparam int unsigned     CntW   = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

    localparam logic [4:0] XMin = 5'd1;
    localparam logic [4:0] XMax = 5'd20;
    localparam logic [3:0] YMax = 4'd14;

    // Bit order used for all per-button vectors: 0 up, 1 down, 2 left, 3 right.
    logic [3:0] raw;
    logic [3:0] stable;
    logic [3:0] prev_q;
    logic [3:0] release_evt;

    logic [4:0] x_q, x_d;
    logic [3:0] y_q, y_d;
    logic       rst_out_q;

    assign raw = {bus.i_player_right, bus.i_player_left, bus.i_player_down, bus.i_player_up};

    for (genvar b = 0; b < 4; b++) begin : g_debounce
        logic [CntW-1:0] cnt_q;
        logic            stable_q;

        // A new level is accepted only after it has been seen for DEBOUNCE_LIMIT edges in a row.
        always_ff @(posedge i_Clk or posedge i_reset) begin
            if (i_reset) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else if (raw[b] != stable_q) begin
                if (cnt_q == CntMax) begin
                    stable_q <= raw[b];
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end

        assign stable[b] = stable_q;
    end

    // Delayed copy of the debounced levels for falling-edge (release) detection.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= stable;
        end
    end

    assign release_evt = ~stable & prev_q;

    // Next position: respawn overrides everything, otherwise the highest-priority release moves.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (y_q == 4'd0) begin
            x_d = PLAYER_ORIGIN_X;
            y_d = PLAYER_ORIGIN_Y;
        end else if (release_evt[0]) begin
            // y_q is known non-zero here, so the step up never underflows.
            y_d = y_q - 4'd1;
        end else if (release_evt[1]) begin
            if (y_q < YMax) begin
                y_d = y_q + 4'd1;
            end
        end else if (release_evt[2]) begin
            if (x_q > XMin) begin
                x_d = x_q - 5'd1;
            end
        end else if (release_evt[3]) begin
            if (x_q < XMax) begin
                x_d = x_q + 5'd1;
            end
        end
    end

    // Position registers plus the downstream reset flag, which drops on the first edge out of reset.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            x_q       <= PLAYER_ORIGIN_X;
            y_q       <= PLAYER_ORIGIN_Y;
            rst_out_q <= 1'b1;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            rst_out_q <= 1'b0;
        end
    end

    assign bus.o_player_x = x_q;
    assign bus.o_player_y = y_q;
    assign bus.o_reset    = rst_out_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl with a window-based behavioural model that is
// compared against the outputs on every falling clock edge.
module tb_player_move_ctrl;

    localparam int LIMIT = 4;
    localparam int OX    = 11;
    localparam int OY    = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    player_move_ctrl_if bus ();

    player_move_ctrl #(
        .PLAYER_ORIGIN_X (5'd11),
        .PLAYER_ORIGIN_Y (4'd14),
        .DEBOUNCE_LIMIT  (LIMIT)
    ) dut (
        .i_Clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model state: button level accepted once the last LIMIT samples all disagree with it.
    logic [LIMIT-1:0] m_win [4];
    int               m_seen[4];
    logic             m_stab[4];
    logic             m_prev[4];
    int               m_x    = OX;
    int               m_y    = OY;
    int               m_orst = 1;

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_win[b]  = '0;
            m_seen[b] = 0;
            m_stab[b] = 1'b0;
            m_prev[b] = 1'b0;
        end
        m_x    = OX;
        m_y    = OY;
        m_orst = 1;
    endtask

    task automatic model_step();
        logic [3:0] raw;
        logic       rel[4];
        raw = {bus.i_player_right, bus.i_player_left, bus.i_player_down, bus.i_player_up};
        for (int b = 0; b < 4; b++) begin
            rel[b]    = !m_stab[b] && m_prev[b];
            m_prev[b] = m_stab[b];
            m_win[b]  = {m_win[b][LIMIT-2:0], raw[b]};
            if (m_seen[b] < LIMIT) m_seen[b]++;
            if (m_seen[b] >= LIMIT && m_win[b] == {LIMIT{~m_stab[b]}}) m_stab[b] = raw[b];
        end
        if (m_y == 0) begin
            m_x = OX;
            m_y = OY;
        end else if (rel[0]) begin
            if (m_y > 0) m_y--;
        end else if (rel[1]) begin
            if (m_y < 14) m_y++;
        end else if (rel[2]) begin
            if (m_x > 1) m_x--;
        end else if (rel[3]) begin
            if (m_x < 20) m_x++;
        end
        m_orst = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Continuous comparison against the model.
    always @(negedge clk) begin
        check("x_vs_model", int'(bus.o_player_x), m_x);
        check("y_vs_model", int'(bus.o_player_y), m_y);
        check("o_reset_vs_model", int'(bus.o_reset), m_orst);
    end

    task automatic set_btn(input logic [3:0] m);
        bus.i_player_up    = m[0];
        bus.i_player_down  = m[1];
        bus.i_player_left  = m[2];
        bus.i_player_right = m[3];
    endtask

    task automatic click(input logic [3:0] m);
        @(negedge clk);
        set_btn(m);
        repeat (6) @(negedge clk);
        set_btn(4'b0000);
        repeat (6) @(negedge clk);
    endtask

    int found;

    initial begin
        set_btn(4'b0000);
        repeat (2) @(negedge clk);
        check("reset_x", int'(bus.o_player_x), 11);
        check("reset_y", int'(bus.o_player_y), 14);
        check("reset_o_reset_high", int'(bus.o_reset), 1);
        rst = 1'b0;
        #1 check("o_reset_held_until_edge", int'(bus.o_reset), 1);
        @(negedge clk);
        check("o_reset_low_after_edge", int'(bus.o_reset), 0);

        // Glitch of two cycles is never accepted.
        set_btn(4'b0001);
        repeat (2) @(negedge clk);
        set_btn(4'b0000);
        repeat (8) @(negedge clk);
        check("glitch_y", int'(bus.o_player_y), 14);

        // Down at the bottom row is consumed without change.
        click(4'b0010);
        check("down_at_limit_y", int'(bus.o_player_y), 14);

        // Long hold then release moves up exactly once.
        @(negedge clk);
        set_btn(4'b0001);
        repeat (10) @(negedge clk);
        set_btn(4'b0000);
        repeat (10) @(negedge clk);
        check("up_once_y", int'(bus.o_player_y), 13);
        check("up_once_x", int'(bus.o_player_x), 11);

        // Simultaneous up and right release: up wins, right is dropped.
        click(4'b1001);
        check("prio_y", int'(bus.o_player_y), 12);
        check("prio_x", int'(bus.o_player_x), 11);

        for (int i = 0; i < 10; i++) click(4'b1000);
        check("right_clamp_x", int'(bus.o_player_x), 20);
        for (int i = 0; i < 20; i++) click(4'b0100);
        check("left_clamp_x", int'(bus.o_player_x), 1);
        check("left_clamp_y", int'(bus.o_player_y), 12);

        // Reset mid-run with up held: position restored at once, button must re-qualify.
        @(negedge clk);
        set_btn(4'b0001);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_x", int'(bus.o_player_x), 11);
        check("midreset_y", int'(bus.o_player_y), 14);
        check("midreset_o_reset", int'(bus.o_reset), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        set_btn(4'b0000);
        repeat (6) @(negedge clk);
        check("after_reset_move_y", int'(bus.o_player_y), 13);
        check("after_reset_move_x", int'(bus.o_player_x), 11);

        // Walk to the top row: y==0 shows for one cycle, then respawn.
        for (int i = 0; i < 12; i++) click(4'b0001);
        check("row1_y", int'(bus.o_player_y), 1);
        @(negedge clk);
        set_btn(4'b0001);
        repeat (6) @(negedge clk);
        set_btn(4'b0000);
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            @(negedge clk);
            if (bus.o_player_y == 4'd0) found = 1;
        end
        check("top_row_reached", found, 1);
        @(negedge clk);
        check("respawn_y", int'(bus.o_player_y), 14);
        check("respawn_x", int'(bus.o_player_x), 11);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
